// File: rtl/uart_imem_loader.sv
// Boot loader: streams UART bytes into instruction memory and holds the core in
// reset until the halt terminator (four 0xFF bytes) or an idle timeout.
module uart_imem_loader #(
   parameter int MEM_BYTES    = 1024,
   parameter int ADDR_W       = 10,
   parameter int IDLE_TIMEOUT = 200000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [7:0]        imem_wdata,
   output logic              core_rst,
   output logic              load_done,
   output logic              overflow,
   output logic [ADDR_W:0]   byte_count
);

   localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_TIMEOUT > 0) ? (IDLE_TIMEOUT - 1) : 0);
   localparam logic [ADDR_W:0] MEM_FULL = (ADDR_W + 1)'(MEM_BYTES);
   localparam logic TIMEOUT_EN = (IDLE_TIMEOUT > 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              core_rst_q, core_rst_d;
   logic              load_done_q, load_done_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [2:0]        ff_run_q, ff_run_d;
   logic [IW-1:0]     idle_q, idle_d;

   // Next-state logic: accept bytes, track the 0xFF run and the idle timer
   always_comb begin
      state_d     = state_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      ovf_d       = ovf_q;
      count_d     = count_q;
      ff_run_d    = ff_run_q;
      idle_d      = idle_q;
      core_rst_d  = 1'b1;
      load_done_d = 1'b0;

      case (state_q)
         S_IDLE, S_LOAD: begin
            if (rx_valid) begin
               idle_d  = '0;
               state_d = S_LOAD;
               // A full memory drops the byte but still feeds terminator detection
               if (count_q == MEM_FULL) begin
                  ovf_d = 1'b1;
               end else begin
                  we_d    = 1'b1;
                  addr_d  = count_q[ADDR_W-1:0];
                  wdata_d = rx_byte;
                  count_d = count_q + 1'b1;
               end
               if (rx_byte == 8'hFF) begin
                  ff_run_d = ff_run_q + 3'd1;
                  if (ff_run_q == 3'd3) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_LOAD;
                  end
               end else begin
                  ff_run_d = 3'd0;
               end
            end else if ((state_q == S_LOAD) && TIMEOUT_EN) begin
               if (idle_q == IDLE_LAST) begin
                  state_d = S_DONE;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_DONE) begin
         core_rst_d  = 1'b0;
         load_done_d = 1'b1;
      end else begin
         core_rst_d  = 1'b1;
         load_done_d = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 8'h00;
         core_rst_q  <= 1'b1;
         load_done_q <= 1'b0;
         ovf_q       <= 1'b0;
         count_q     <= '0;
         ff_run_q    <= 3'd0;
         idle_q      <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         core_rst_q  <= core_rst_d;
         load_done_q <= load_done_d;
         ovf_q       <= ovf_d;
         count_q     <= count_d;
         ff_run_q    <= ff_run_d;
         idle_q      <= idle_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign core_rst   = core_rst_q;
   assign load_done  = load_done_q;
   assign overflow   = ovf_q;
   assign byte_count = count_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed + randomized bench for uart_imem_loader against a cycle-level
// behavioural model (small memory and short timeout for reachability).
module tb_uart_imem_loader;

   localparam int MEM = 16;
   localparam int AW  = 4;
   localparam int TMO = 40;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_byte = 8'h00;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [7:0]    imem_wdata;
   logic          core_rst;
   logic          load_done;
   logic          overflow;
   logic [AW:0]   byte_count;

   int n_cmp  = 0;
   int n_fail = 0;

   // model state
   bit m_started, m_done, m_ovf;
   int m_count, m_run, m_idle;

   uart_imem_loader #(.MEM_BYTES(MEM), .ADDR_W(AW), .IDLE_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_rst(core_rst), .load_done(load_done), .overflow(overflow),
      .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
      m_count = 0; m_run = 0; m_idle = 0;
   endtask

   task automatic chk_status(input string tag);
      chk({tag, ".core_rst"},  32'(core_rst),   32'(!m_done));
      chk({tag, ".load_done"}, 32'(load_done),  32'(m_done));
      chk({tag, ".overflow"},  32'(overflow),   32'(m_ovf));
      chk({tag, ".count"},     32'(byte_count), 32'(m_count));
   endtask

   // One clock: present (v,b), advance model, check registered outputs after the edge
   task automatic step(input logic v, input logic [7:0] b);
      bit exp_we;
      int exp_addr;
      exp_we = 1'b0; exp_addr = 0;
      rx_valid = v;
      rx_byte  = v ? b : 8'($urandom);
      if (!m_done && v) begin
         m_started = 1'b1;
         m_idle = 0;
         if (m_count < MEM) begin
            exp_we = 1'b1; exp_addr = m_count; m_count++;
         end else begin
            m_ovf = 1'b1;
         end
         m_run = (b == 8'hFF) ? m_run + 1 : 0;
         if (m_run >= 4) m_done = 1'b1;
      end else if (!m_done && m_started) begin
         m_idle++;
         if (m_idle == TMO) m_done = 1'b1;
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
      chk("we", 32'(imem_we), 32'(exp_we));
      if (exp_we) begin
         chk("addr",  32'(imem_addr),  32'(exp_addr));
         chk("wdata", 32'(imem_wdata), 32'(b));
      end
      chk_status("st");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      step(1'b1, b);
      idle(gap);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      model_reset();
      chk("rst.we", 32'(imem_we), 32'd0);
      chk("rst.addr", 32'(imem_addr), 32'd0);
      chk("rst.wdata", 32'(imem_wdata), 32'd0);
      chk_status("rst");
      rst = 1'b0;
   endtask

   logic [7:0] seq_a [10] = '{8'h13, 8'h01, 8'h20, 8'h00, 8'hF5, 8'h0E, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
   logic [7:0] seq_b [8]  = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
   logic [7:0] seq_c [4]  = '{8'h93, 8'h00, 8'h10, 8'h00};

   initial begin
      model_reset();
      // reset state and timeout completion
      do_reset();
      idle(3);
      for (int i = 0; i < 4; i++) send(seq_c[i], $urandom_range(0, 3));
      idle(TMO + 5);

      // terminator after mixed 32/16-bit instructions, then ignored byte in DONE
      do_reset();
      for (int i = 0; i < 10; i++) send(seq_a[i], 0);
      idle(2);
      send(8'hAA, 3);

      // broken run does not terminate
      do_reset();
      for (int i = 0; i < 8; i++) send(seq_b[i], $urandom_range(0, 2));
      idle(2);

      // back-to-back bytes
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 254)));
      idle(3);

      // async reset mid-load, then next byte lands at address 0
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom_range(0, 254)));
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("arst.we", 32'(imem_we), 32'd0);
      chk("arst.addr", 32'(imem_addr), 32'd0);
      chk_status("arst");
      @(posedge clk); #1;
      rst = 1'b0;
      send(8'h55, 2);

      // overflow, then terminator still completes the load
      do_reset();
      for (int i = 0; i < 17; i++) send(8'($urandom_range(0, 254)), $urandom_range(0, 2));
      send(8'h11, 1);
      for (int i = 0; i < 4; i++) send(8'hFF, 0);
      idle(3);

      // random streams, occasionally long gaps that hit the timeout
      for (int r = 0; r < 6; r++) begin
         do_reset();
         idle($urandom_range(0, 4));
         for (int i = 0; i < 24; i++) begin
            send(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                 ($urandom_range(0, 15) == 0) ? $urandom_range(TMO - 2, TMO + 2)
                                              : $urandom_range(0, 2));
         end
         idle(TMO + 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
